// File: rtl/core_seq_pkg.sv
// ---------------------------------------------------------------------------
// core_seq_pkg
// Shared definitions for the core sequencer: the controller state encoding,
// the bit layout of the 19-bit core instruction word and the mac_array
// operation codes.
//
// Instruction word layout (MSB to LSB):
//   [18] div        [17] acc        [16] ofifo_rd
//   [15:12] qkmem_add               [11:8] pmem_add
//   [7:6] mac op    [5] qmem_rd     [4] qmem_wr
//   [3] kmem_rd     [2] kmem_wr     [1] pmem_rd     [0] pmem_wr
// ---------------------------------------------------------------------------
package core_seq_pkg;

    // Controller states; the encoding is exported unchanged on the phase port.
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        LD_Q  = 4'd1,
        LD_K  = 4'd2,
        K2ARR = 4'd3,
        EXEC  = 4'd4,
        DRAIN = 4'd5,
        OF2P  = 4'd6,
        SFP   = 4'd7,
        DIV   = 4'd8,
        DONE  = 4'd9
    } state_e;

    // Width of each SRAM address field inside the instruction word.
    localparam int ADDR_W = 4;

    // Bit positions of the single-bit fields.
    localparam int INST_DIV_BIT      = 18;
    localparam int INST_ACC_BIT      = 17;
    localparam int INST_OFIFO_RD_BIT = 16;
    localparam int INST_QMEM_RD_BIT  = 5;
    localparam int INST_QMEM_WR_BIT  = 4;
    localparam int INST_KMEM_RD_BIT  = 3;
    localparam int INST_KMEM_WR_BIT  = 2;
    localparam int INST_PMEM_RD_BIT  = 1;
    localparam int INST_PMEM_WR_BIT  = 0;

    // LSB positions of the multi-bit fields.
    localparam int INST_QK_ADD_LSB   = 12;
    localparam int INST_P_ADD_LSB    = 8;
    localparam int INST_MAC_OP_LSB   = 6;

    // mac_array operation codes.
    localparam logic [1:0] MAC_OP_NOP   = 2'b00;
    localparam logic [1:0] MAC_OP_KLOAD = 2'b01;
    localparam logic [1:0] MAC_OP_EXEC  = 2'b10;

endpackage

// File: rtl/core_seq_inst_pack.sv
// ---------------------------------------------------------------------------
// core_seq_inst_pack
// Purely combinational packing of the individual instruction fields into the
// core instruction word. The parent registers the result.
//
// Ports:
//   div_i, acc_i, ofifoRd_i      SFP divide / accumulate, OFIFO read
//   qkmemAdd_i [3:0]             shared Q/K SRAM address
//   pmemAdd_i  [3:0]             PSUM SRAM address
//   macOp_i    [1:0]             mac_array operation
//   qmemRd_i, qmemWr_i           Q SRAM read / write strobes
//   kmemRd_i, kmemWr_i           K SRAM read / write strobes
//   pmemRd_i, pmemWr_i           PSUM SRAM read / write strobes
//   inst_o     [INST_W-1:0]      packed instruction word
// ---------------------------------------------------------------------------
module core_seq_inst_pack
    import core_seq_pkg::*;
#(
    parameter int INST_W = 19
) (
    input  logic              div_i,
    input  logic              acc_i,
    input  logic              ofifoRd_i,
    input  logic [3:0]        qkmemAdd_i,
    input  logic [3:0]        pmemAdd_i,
    input  logic [1:0]        macOp_i,
    input  logic              qmemRd_i,
    input  logic              qmemWr_i,
    input  logic              kmemRd_i,
    input  logic              kmemWr_i,
    input  logic              pmemRd_i,
    input  logic              pmemWr_i,
    output logic [INST_W-1:0] inst_o
);

    // Every field lands on its fixed bit position; unused bits stay zero.
    always_comb begin
        inst_o                                   = '0;
        inst_o[INST_DIV_BIT]                     = div_i;
        inst_o[INST_ACC_BIT]                     = acc_i;
        inst_o[INST_OFIFO_RD_BIT]                = ofifoRd_i;
        inst_o[INST_QK_ADD_LSB +: ADDR_W]        = qkmemAdd_i;
        inst_o[INST_P_ADD_LSB +: ADDR_W]         = pmemAdd_i;
        inst_o[INST_MAC_OP_LSB +: 2]             = macOp_i;
        inst_o[INST_QMEM_RD_BIT]                 = qmemRd_i;
        inst_o[INST_QMEM_WR_BIT]                 = qmemWr_i;
        inst_o[INST_KMEM_RD_BIT]                 = kmemRd_i;
        inst_o[INST_KMEM_WR_BIT]                 = kmemWr_i;
        inst_o[INST_PMEM_RD_BIT]                 = pmemRd_i;
        inst_o[INST_PMEM_WR_BIT]                 = pmemWr_i;
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// ---------------------------------------------------------------------------
// core_seq_ctrl
// Sequencer that produces one core instruction word per clock and runs one
// complete attention tile per accepted start:
//   Q load -> K load -> kernel load into mac_array -> Q execute -> drain
//   -> OFIFO-to-PSUM move -> SFP accumulate -> SFP divide -> done.
// Q and K data arrive from the host on mem_in under an in_valid/in_ready
// handshake; the controller only generates the control word.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset (aborts a tile immediately)
//   start      begin a tile; only looked at in IDLE
//   n_rows     rows-1 of the tile, latched on the accepted start
//   in_valid   host data beat valid
//   in_ready   controller consumes mem_in this cycle (LD_Q / LD_K)
//   inst       registered core instruction word
//   busy       high from the cycle after the accepted start through DONE
//   done       one-cycle pulse while in DONE
//   phase      current state encoding
//   perf_cyc   (only with CORE_SEQ_CTRL_PERF_EN) tile cycle counter
//
// Build option:
//   CORE_SEQ_CTRL_PERF_EN  adds perf_cyc[15:0] and its saturating counter.
//
// The instruction word is registered, so inst shows the word generated by
// the state of the previous cycle.
// ---------------------------------------------------------------------------
module core_seq_ctrl
    import core_seq_pkg::*;
#(
    parameter int ROWS_W    = 4,
    parameter int DRAIN_CYC = 24,
    parameter int INST_W    = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROWS_W-1:0] n_rows,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic [3:0]        phase
`ifdef CORE_SEQ_CTRL_PERF_EN
    ,
    output logic [15:0]       perf_cyc
`endif
);

    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_e              state_q, state_d;
    logic [ROWS_W-1:0]   rowCnt_q, rowCnt_d;
    logic [ROWS_W-1:0]   nRows_q, nRows_d;
    logic [DRAIN_W-1:0]  drainCnt_q, drainCnt_d;
    logic                sfpTail_q, sfpTail_d;
    logic [INST_W-1:0]   inst_q;
    logic [INST_W-1:0]   instNext;

    logic                lastRow;
    logic                inReady;
    logic                fDiv, fAcc, fOfifoRd;
    logic [ADDR_W-1:0]   fQkAdd, fPAdd;
    logic [1:0]          fMacOp;
    logic                fQmemRd, fQmemWr, fKmemRd, fKmemWr, fPmemRd, fPmemWr;

    // A phase finishes on the cycle that issues row n_rows.
    assign lastRow = (rowCnt_q == nRows_q);

    // Next-state and instruction-field decode. Each row phase steps rowCnt
    // from 0 up to n_rows and clears it on the way out, so the counter never
    // has to wrap. SFP needs one extra cycle for the trailing accumulate that
    // follows the last PSUM read; sfpTail marks that cycle instead of letting
    // rowCnt run to n_rows+1, which would overflow for a 16-row tile.
    always_comb begin
        state_d    = state_q;
        rowCnt_d   = rowCnt_q;
        nRows_d    = nRows_q;
        drainCnt_d = drainCnt_q;
        sfpTail_d  = sfpTail_q;
        inReady    = 1'b0;
        fDiv       = 1'b0;
        fAcc       = 1'b0;
        fOfifoRd   = 1'b0;
        fQkAdd     = '0;
        fPAdd      = '0;
        fMacOp     = MAC_OP_NOP;
        fQmemRd    = 1'b0;
        fQmemWr    = 1'b0;
        fKmemRd    = 1'b0;
        fKmemWr    = 1'b0;
        fPmemRd    = 1'b0;
        fPmemWr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LD_Q;
                    rowCnt_d  = '0;
                    nRows_d   = n_rows;
                    sfpTail_d = 1'b0;
                end
            end

            LD_Q: begin
                inReady = 1'b1;
                if (in_valid) begin
                    fQmemWr = 1'b1;
                    fQkAdd  = ADDR_W'(rowCnt_q);
                    if (lastRow) begin
                        rowCnt_d = '0;
                        state_d  = LD_K;
                    end else begin
                        rowCnt_d = rowCnt_q + ROWS_W'(1);
                    end
                end
            end

            LD_K: begin
                inReady = 1'b1;
                if (in_valid) begin
                    fKmemWr = 1'b1;
                    fQkAdd  = ADDR_W'(rowCnt_q);
                    if (lastRow) begin
                        rowCnt_d = '0;
                        state_d  = K2ARR;
                    end else begin
                        rowCnt_d = rowCnt_q + ROWS_W'(1);
                    end
                end
            end

            K2ARR: begin
                fKmemRd = 1'b1;
                fMacOp  = MAC_OP_KLOAD;
                fQkAdd  = ADDR_W'(rowCnt_q);
                if (lastRow) begin
                    rowCnt_d = '0;
                    state_d  = EXEC;
                end else begin
                    rowCnt_d = rowCnt_q + ROWS_W'(1);
                end
            end

            EXEC: begin
                fQmemRd = 1'b1;
                fMacOp  = MAC_OP_EXEC;
                fQkAdd  = ADDR_W'(rowCnt_q);
                if (lastRow) begin
                    rowCnt_d   = '0;
                    drainCnt_d = DRAIN_W'(DRAIN_CYC - 1);
                    state_d    = DRAIN;
                end else begin
                    rowCnt_d = rowCnt_q + ROWS_W'(1);
                end
            end

            DRAIN: begin
                if (drainCnt_q == '0) begin
                    state_d = OF2P;
                end else begin
                    drainCnt_d = drainCnt_q - DRAIN_W'(1);
                end
            end

            OF2P: begin
                fOfifoRd = 1'b1;
                fPmemWr  = 1'b1;
                fPAdd    = ADDR_W'(rowCnt_q);
                if (lastRow) begin
                    rowCnt_d = '0;
                    state_d  = SFP;
                end else begin
                    rowCnt_d = rowCnt_q + ROWS_W'(1);
                end
            end

            SFP: begin
                if (!sfpTail_q) begin
                    fPmemRd = 1'b1;
                    fPAdd   = ADDR_W'(rowCnt_q);
                    fAcc    = (rowCnt_q != '0);
                    if (lastRow) begin
                        rowCnt_d  = '0;
                        sfpTail_d = 1'b1;
                    end else begin
                        rowCnt_d = rowCnt_q + ROWS_W'(1);
                    end
                end else begin
                    fAcc      = 1'b1;
                    sfpTail_d = 1'b0;
                    state_d   = DIV;
                end
            end

            DIV: begin
                fDiv = 1'b1;
                if (lastRow) begin
                    rowCnt_d = '0;
                    state_d  = DONE;
                end else begin
                    rowCnt_d = rowCnt_q + ROWS_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    core_seq_inst_pack #(
        .INST_W     (INST_W)
    ) u_inst_pack (
        .div_i      (fDiv),
        .acc_i      (fAcc),
        .ofifoRd_i  (fOfifoRd),
        .qkmemAdd_i (fQkAdd),
        .pmemAdd_i  (fPAdd),
        .macOp_i    (fMacOp),
        .qmemRd_i   (fQmemRd),
        .qmemWr_i   (fQmemWr),
        .kmemRd_i   (fKmemRd),
        .kmemWr_i   (fKmemWr),
        .pmemRd_i   (fPmemRd),
        .pmemWr_i   (fPmemWr),
        .inst_o     (instNext)
    );

    // State, counters and the registered instruction word. Reset clears
    // everything in one cycle, abandoning any tile in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rowCnt_q   <= '0;
            nRows_q    <= '0;
            drainCnt_q <= '0;
            sfpTail_q  <= 1'b0;
            inst_q     <= '0;
        end else begin
            state_q    <= state_d;
            rowCnt_q   <= rowCnt_d;
            nRows_q    <= nRows_d;
            drainCnt_q <= drainCnt_d;
            sfpTail_q  <= sfpTail_d;
            inst_q     <= instNext;
        end
    end

`ifdef CORE_SEQ_CTRL_PERF_EN
    logic [15:0] perfCnt_q;

    // Tile cycle counter: cleared by the accepted start, counts the busy
    // cycles leading up to DONE and then holds until the next start. The
    // DONE cycle itself is not counted, so the held value equals the number
    // of cycles from LD_Q entry to the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            perfCnt_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            perfCnt_q <= '0;
        end else if ((state_q != IDLE) && (state_q != DONE) &&
                     (perfCnt_q != 16'hFFFF)) begin
            perfCnt_q <= perfCnt_q + 16'd1;
        end
    end

    assign perf_cyc = perfCnt_q;
`endif

    assign in_ready = inReady;
    assign inst     = inst_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign phase    = state_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_seq_ctrl
// Scoreboard bench for core_seq_ctrl. Stimulus tasks push every non-zero
// instruction word a tile must produce, plus the cycle number of its done
// pulse, into queues; an independent monitor pops and compares whenever the
// DUT shows a non-zero inst word or a done pulse.
// ---------------------------------------------------------------------------
module tb_core_seq_ctrl;

    localparam int DRAIN = 24;

    localparam logic [18:0] B_DIV     = 19'h40000;
    localparam logic [18:0] B_ACC     = 19'h20000;
    localparam logic [18:0] B_OFRD    = 19'h10000;
    localparam logic [18:0] B_OPEXEC  = 19'h00080;
    localparam logic [18:0] B_OPKLOAD = 19'h00040;
    localparam logic [18:0] B_QMEM_RD = 19'h00020;
    localparam logic [18:0] B_QMEM_WR = 19'h00010;
    localparam logic [18:0] B_KMEM_RD = 19'h00008;
    localparam logic [18:0] B_KMEM_WR = 19'h00004;
    localparam logic [18:0] B_PMEM_RD = 19'h00002;
    localparam logic [18:0] B_PMEM_WR = 19'h00001;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  n_rows;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  phase;
`ifdef CORE_SEQ_CTRL_PERF_EN
    logic [15:0] perf_cyc;
`endif

    int          cycle = 0;
    int          passCnt = 0;
    int          totalCnt = 0;
    bit          monEn = 1'b0;
    logic [18:0] expInst[$];
    int          expDone[$];

    core_seq_ctrl #(
        .ROWS_W    (4),
        .DRAIN_CYC (DRAIN),
        .INST_W    (19)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .n_rows   (n_rows),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inst     (inst),
        .busy     (busy),
        .done     (done),
        .phase    (phase)
`ifdef CORE_SEQ_CTRL_PERF_EN
        ,
        .perf_cyc (perf_cyc)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
    endtask

    function automatic logic [18:0] qkAdd(input int k);
        return 19'(k) << 12;
    endfunction

    function automatic logic [18:0] pAdd(input int k);
        return 19'(k) << 8;
    endfunction

    function automatic void pushLoads(input int n);
        for (int k = 0; k <= n; k++) expInst.push_back(B_QMEM_WR | qkAdd(k));
        for (int k = 0; k <= n; k++) expInst.push_back(B_KMEM_WR | qkAdd(k));
        for (int k = 0; k <= n; k++) expInst.push_back(B_KMEM_RD | B_OPKLOAD | qkAdd(k));
    endfunction

    function automatic void pushExec(input int cnt);
        for (int k = 0; k < cnt; k++) expInst.push_back(B_QMEM_RD | B_OPEXEC | qkAdd(k));
    endfunction

    function automatic void pushBack(input int n);
        for (int k = 0; k <= n; k++) expInst.push_back(B_OFRD | B_PMEM_WR | pAdd(k));
        for (int k = 0; k <= n; k++) expInst.push_back(B_PMEM_RD | pAdd(k) | ((k > 0) ? B_ACC : 19'h0));
        expInst.push_back(B_ACC);
        for (int k = 0; k <= n; k++) expInst.push_back(B_DIV);
    endfunction

    function automatic void pushTile(input int n);
        pushLoads(n);
        pushExec(n + 1);
        pushBack(n);
    endfunction

    // Scoreboard monitor: consumes one expected word per non-zero inst.
    always @(negedge clk) begin
        logic [18:0] e;
        int          d;
        if (monEn) begin
            if (inst !== 19'h0) begin
                if (expInst.size() == 0) begin
                    checkOutput("inst_unexpected", 32'(inst), 32'h0);
                end else begin
                    e = expInst.pop_front();
                    checkOutput("inst_word", 32'(inst), 32'(e));
                end
            end
            if (done !== 1'b0) begin
                if (expDone.size() == 0) begin
                    checkOutput("done_unexpected", 32'(done), 32'h0);
                end else begin
                    d = expDone.pop_front();
                    checkOutput("done_cycle", cycle, d);
                    checkOutput("busy_at_done", 32'(busy), 32'h1);
                end
            end
        end
    end

    // One full tile; gaps inserts an idle in_valid cycle between Q beats.
    task automatic applyStimulus(input int n, input bit gaps);
        int entry;
        int lat;
        int gapCyc;
        lat    = 7 * (n + 1) + 1 + DRAIN;
        gapCyc = gaps ? n : 0;
        @(negedge clk);
        start    = 1'b1;
        n_rows   = 4'(n);
        in_valid = 1'b0;
        entry    = cycle + 1;
        pushTile(n);
        expDone.push_back(entry + lat + gapCyc);
        @(negedge clk);
        start = 1'b0;
        checkOutput("phase_ld_q", 32'(phase), 32'd1);
`ifdef CORE_SEQ_CTRL_PERF_EN
        checkOutput("perf_clear", 32'(perf_cyc), 32'd0);
`endif
        for (int i = 0; i <= n; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            if (gaps && i < n) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        for (int i = 0; i <= n; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (lat - 2 * (n + 1) + 3) @(negedge clk);
        checkOutput("phase_idle_after", 32'(phase), 32'd0);
        checkOutput("busy_after", 32'(busy), 32'd0);
        checkOutput("inst_queue_empty", expInst.size(), 32'd0);
        checkOutput("done_queue_empty", expDone.size(), 32'd0);
`ifdef CORE_SEQ_CTRL_PERF_EN
        checkOutput("perf_total", 32'(perf_cyc), 32'(lat + gapCyc));
`endif
    endtask

    initial begin
        int entry;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        n_rows   = 4'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_inst", 32'(inst), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'h0);
        checkOutput("reset_phase", 32'(phase), 32'h0);
`ifdef CORE_SEQ_CTRL_PERF_EN
        checkOutput("reset_perf", 32'(perf_cyc), 32'h0);
`endif
        reset = 1'b0;
        monEn = 1'b1;

        // T2: four rows, continuous data, done 53 cycles after LD_Q entry
        applyStimulus(3, 1'b0);
        // T4: three rows, SFP read/accumulate overlap and three divides
        applyStimulus(2, 1'b0);
        // T3: sixteen rows with gaps between Q beats
        applyStimulus(15, 1'b1);
        // single-row boundary
        applyStimulus(0, 1'b0);

        // T1: reset during EXEC row 2 of a four-row tile
        @(negedge clk);
        start    = 1'b1;
        n_rows   = 4'd3;
        in_valid = 1'b0;
        entry    = cycle + 1;
        pushLoads(3);
        pushExec(2);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("t1_in_exec", 32'(phase), 32'd4);
        checkOutput("t1_cycle", cycle, entry + 14);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t1_inst", 32'(inst), 32'h0);
        checkOutput("t1_busy", 32'(busy), 32'h0);
        checkOutput("t1_phase", 32'(phase), 32'h0);
        checkOutput("t1_in_ready", 32'(in_ready), 32'h0);
        reset = 1'b0;
        checkOutput("t1_inst_queue", expInst.size(), 32'd0);
        applyStimulus(3, 1'b0);

        // T5: start held high; one IDLE cycle separates back-to-back tiles
        @(negedge clk);
        start    = 1'b1;
        n_rows   = 4'd0;
        in_valid = 1'b1;
        entry    = cycle + 1;
        pushTile(0);
        expDone.push_back(entry + 32);
        pushTile(0);
        expDone.push_back(entry + 66);
        repeat (34) @(negedge clk);
        checkOutput("t5_idle_between", 32'(phase), 32'd0);
        checkOutput("t5_busy_between", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("t5_restart", 32'(phase), 32'd1);
        start = 1'b0;
        repeat (36) @(negedge clk);
        in_valid = 1'b0;
        checkOutput("t5_idle_end", 32'(phase), 32'd0);
        checkOutput("t5_inst_queue", expInst.size(), 32'd0);
        checkOutput("t5_done_queue", expDone.size(), 32'd0);

`ifdef CORE_SEQ_CTRL_PERF_EN
        // T6: single-row tile counts 32 cycles, holds, then clears on start
        applyStimulus(0, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("t6_perf_hold", 32'(perf_cyc), 32'd32);
        applyStimulus(0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
